// File: rtl/spad_sequencer.sv
// rtl/spad_sequencer.sv - scratchpad fill/replay sequencer (LOAD then multi-pass read stream)
module spad_sequencer #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic [ADDR_BITWIDTH:0]   i_cfg_len,
  input  logic [7:0]               i_cfg_passes,
  input  logic                     i_in_valid,
  input  logic [DATA_BITWIDTH-1:0] i_in_data,
  output logic                     o_in_ready,
  output logic                     o_rf_en,
  output logic                     o_rf_we,
  output logic [ADDR_BITWIDTH-1:0] o_rf_wr_addr,
  output logic [ADDR_BITWIDTH-1:0] o_rf_rd_addr,
  output logic [DATA_BITWIDTH-1:0] o_rf_din,
  input  logic [DATA_BITWIDTH-1:0] i_rf_dout,
  output logic                     o_out_valid,
  output logic [DATA_BITWIDTH-1:0] o_out_data,
  output logic                     o_out_last,
  input  logic                     i_out_ready,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  // Pointers carry one extra bit so a full-depth length (D) is representable.
  localparam logic [ADDR_BITWIDTH:0] DEPTH   = {1'b1, {ADDR_BITWIDTH{1'b0}}};
  localparam logic [ADDR_BITWIDTH:0] PTR_ONE = {{ADDR_BITWIDTH{1'b0}}, 1'b1};

  state_e                 r_state;
  state_e                 w_next;
  logic [ADDR_BITWIDTH:0] r_len;
  logic [7:0]             r_passes;
  logic [ADDR_BITWIDTH:0] r_wr_ptr;
  logic [ADDR_BITWIDTH:0] r_rd_ptr;
  logic [7:0]             r_pass_cnt;

  logic                   w_cfg_ok;
  logic [ADDR_BITWIDTH:0] w_len_m1;
  logic                   w_rd_at_end;
  logic                   w_last_pass;
  logic                   w_wr_fire;
  logic                   w_rd_fire;

  assign w_cfg_ok    = (i_cfg_len != '0) && (i_cfg_len <= DEPTH) && (i_cfg_passes != 8'd0);
  assign w_len_m1    = r_len - PTR_ONE;
  assign w_rd_at_end = (r_rd_ptr == w_len_m1);
  assign w_last_pass = (r_pass_cnt == (r_passes - 8'd1));

  // State register; reset drops straight to IDLE so every output reads as idle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and all outputs; clear wins over everything and kills handshakes.
  always_comb begin
    w_next       = r_state;
    o_in_ready   = 1'b0;
    o_rf_en      = 1'b0;
    o_rf_we      = 1'b0;
    o_rf_wr_addr = '0;
    o_rf_rd_addr = '0;
    o_rf_din     = '0;
    o_out_valid  = 1'b0;
    o_out_data   = '0;
    o_out_last   = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = w_cfg_ok ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        o_in_ready   = 1'b1;
        o_rf_we      = i_in_valid;
        o_rf_wr_addr = r_wr_ptr[ADDR_BITWIDTH-1:0];
        o_rf_din     = i_in_data;
        o_busy       = 1'b1;
        w_wr_fire    = i_in_valid;
        if (i_in_valid && (r_wr_ptr == w_len_m1)) begin
          w_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        o_rf_en      = 1'b1;
        o_rf_rd_addr = r_rd_ptr[ADDR_BITWIDTH-1:0];
        o_out_valid  = 1'b1;
        o_out_data   = i_rf_dout;
        o_out_last   = w_rd_at_end;
        o_busy       = 1'b1;
        w_rd_fire    = i_out_ready;
        if (i_out_ready && w_rd_at_end && w_last_pass) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    if (i_clear) begin
      w_next      = S_IDLE;
      o_in_ready  = 1'b0;
      o_rf_we     = 1'b0;
      o_out_valid = 1'b0;
      o_out_last  = 1'b0;
      o_done      = 1'b0;
      w_wr_fire   = 1'b0;
      w_rd_fire   = 1'b0;
    end
  end

  // Job configuration capture and write/read/pass counters.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_len      <= '0;
      r_passes   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
    end else if ((r_state == S_IDLE) && i_start && !i_clear) begin
      if (w_cfg_ok) begin
        r_len    <= i_cfg_len;
        r_passes <= i_cfg_passes;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_fire) begin
        if (w_rd_at_end) begin
          r_rd_ptr   <= '0;
          r_pass_cnt <= r_pass_cnt + 8'd1;
        end else begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_spad_sequencer.sv
// tb/tb_spad_sequencer.sv - scoreboard bench for spad_sequencer
module tb_spad_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          i_start = 1'b0;
  logic          i_clear = 1'b0;
  logic [AW:0]   i_cfg_len = '0;
  logic [7:0]    i_cfg_passes = '0;
  logic          i_in_valid = 1'b0;
  logic [DW-1:0] i_in_data = '0;
  logic          o_in_ready;
  logic          o_rf_en;
  logic          o_rf_we;
  logic [AW-1:0] o_rf_wr_addr;
  logic [AW-1:0] o_rf_rd_addr;
  logic [DW-1:0] o_rf_din;
  logic [DW-1:0] i_rf_dout;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;
  logic          i_out_ready = 1'b0;
  logic          o_busy;
  logic          o_done;

  spad_sequencer #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) dut (
    .clk(clk), .rstN(rstN), .i_start(i_start), .i_clear(i_clear),
    .i_cfg_len(i_cfg_len), .i_cfg_passes(i_cfg_passes),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_rf_en(o_rf_en), .o_rf_we(o_rf_we), .o_rf_wr_addr(o_rf_wr_addr),
    .o_rf_rd_addr(o_rf_rd_addr), .o_rf_din(o_rf_din), .i_rf_dout(i_rf_dout),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
    .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // scratchpad model
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (o_rf_we && !o_rf_en) mem[o_rf_wr_addr] <= o_rf_din;
  assign i_rf_dout = o_rf_en ? mem[o_rf_rd_addr] : '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_beat_cyc = -100;
  logic [11:0] exp_wr [$];
  logic [8:0]  exp_rd [$];
  bit          exp_done [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected none", name, got);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a write, beat or done
  always @(negedge clk) begin
    logic [11:0] w;
    logic [8:0]  r;
    bit          g;
    cyc++;
    if (rstN) begin
      chk("rf_exclusive", {31'd0, o_rf_en & o_rf_we}, 32'd0);
      if (o_rf_we && !o_rf_en) begin
        if (exp_wr.size() == 0) fail_now("unexpected_write", {20'd0, o_rf_wr_addr, o_rf_din});
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", {28'd0, o_rf_wr_addr}, {28'd0, w[11:8]});
          chk("wr_data", {24'd0, o_rf_din}, {24'd0, w[7:0]});
        end
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_rd.size() == 0) fail_now("unexpected_beat", {24'd0, o_out_data});
        else begin
          r = exp_rd.pop_front();
          chk("rd_data", {24'd0, o_out_data}, {24'd0, r[7:0]});
          chk("rd_last", {31'd0, o_out_last}, {31'd0, r[8]});
          if (r[8]) last_beat_cyc = cyc;
        end
      end
      if (o_done) begin
        if (exp_done.size() == 0) fail_now("unexpected_done", 32'd1);
        else begin
          g = exp_done.pop_front();
          if (g) chk("done_gap", cyc, last_beat_cyc + 1);
        end
      end
    end
  end

  task automatic start_job(input int len, input int passes);
    @(posedge clk); #1;
    i_cfg_len = len[AW:0];
    i_cfg_passes = passes[7:0];
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    i_in_valid = 1'b1;
    i_in_data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_in_ready) break;
    end
    if (!o_in_ready) fail_now("in_ready_timeout", {24'd0, d});
    @(posedge clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic accept_beats(input int n);
    i_out_ready = 1'b1;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (o_out_valid) break;
      end
      if (!o_out_valid) fail_now("out_valid_timeout", b);
      @(posedge clk); #1;
    end
    i_out_ready = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 3000 && !empty; k++) begin
      @(negedge clk);
      empty = (exp_wr.size() == 0) && (exp_rd.size() == 0) && (exp_done.size() == 0);
    end
    if (!empty) begin
      fail_now("drain_timeout", exp_wr.size() + exp_rd.size() + exp_done.size());
      exp_wr.delete(); exp_rd.delete(); exp_done.delete();
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic push_job(input logic [7:0] d[$], input int passes, input bit want_done);
    for (int i = 0; i < d.size(); i++) exp_wr.push_back({i[3:0], d[i]});
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < d.size(); i++) exp_rd.push_back({(i == d.size() - 1), d[i]});
    if (want_done) exp_done.push_back(1'b1);
  endtask

  initial begin
    logic [7:0] dq[$];
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dq[$];
    // reset state
    #2;
    chk("reset_outputs", {17'd0, o_in_ready, o_rf_en, o_rf_we, o_out_valid, o_out_last, o_busy, o_done,
                          o_rf_wr_addr, o_rf_rd_addr}, 32'd0);
    chk("reset_data", {16'd0, o_rf_din, o_out_data}, 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, o_busy}, 32'd0);

    // len=4 passes=2 continuous fill
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_job(dq, 2, 1'b1);
    i_out_ready = 1'b1;
    start_job(4, 2);
    chk("load_busy", {31'd0, o_busy}, 32'd1);
    foreach (dq[i]) send_word(dq[i]);
    drain();

    // full depth, in_valid toggling
    dq.delete();
    for (int i = 0; i < 16; i++) dq.push_back(8'hA0 + i[7:0]);
    push_job(dq, 1, 1'b1);
    start_job(16, 1);
    foreach (dq[i]) begin
      send_word(dq[i]);
      @(posedge clk); #1;
    end
    drain();

    // backpressure hold at rd_ptr=2
    dq = '{8'h05, 8'h06, 8'h07, 8'h08};
    push_job(dq, 1, 1'b1);
    i_out_ready = 1'b0;
    start_job(4, 1);
    foreach (dq[i]) send_word(dq[i]);
    accept_beats(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_addr", {28'd0, o_rf_rd_addr}, 32'd2);
      chk("hold_data", {24'd0, o_out_data}, 32'h07);
      chk("hold_valid", {31'd0, o_out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    i_out_ready = 1'b1;
    drain();

    // illegal configs: passes=0, len=0, len>D
    for (int c = 0; c < 3; c++) begin
      exp_done.push_back(1'b0);
      case (c)
        0: start_job(4, 0);
        1: start_job(0, 1);
        default: start_job(17, 1);
      endcase
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("illegal_quiet", {29'd0, o_busy, o_rf_en, o_in_ready}, 32'd0);
      end
      drain();
    end

    // clear at third beat, then a clean job
    dq = '{8'h31, 8'h32, 8'h33, 8'h34};
    foreach (dq[i]) exp_wr.push_back({i[3:0], dq[i]});
    exp_rd.push_back({1'b0, 8'h31});
    exp_rd.push_back({1'b0, 8'h32});
    i_out_ready = 1'b0;
    start_job(4, 2);
    foreach (dq[i]) send_word(dq[i]);
    accept_beats(2);
    i_clear = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    i_out_ready = 1'b0;
    chk("clear_idle", {30'd0, o_busy, o_out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("clear_no_done", {31'd0, o_done}, 32'd0);
    end
    drain();
    dq = '{8'h5A, 8'hA5};
    push_job(dq, 1, 1'b1);
    i_out_ready = 1'b1;
    start_job(2, 1);
    foreach (dq[i]) send_word(dq[i]);
    drain();

    // async reset mid-LOAD after 2 writes
    exp_wr.push_back({4'd0, 8'hC1});
    exp_wr.push_back({4'd1, 8'hC2});
    i_out_ready = 1'b0;
    start_job(4, 1);
    send_word(8'hC1);
    send_word(8'hC2);
    i_in_valid = 1'b1;
    i_in_data = 8'hC3;
    #2;
    rstN = 1'b0;
    #1;
    chk("async_reset_ctl", {28'd0, o_in_ready, o_rf_we, o_busy, o_rf_en}, 32'd0);
    chk("async_reset_dat", {20'd0, o_rf_wr_addr, o_rf_din}, 32'd0);
    i_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_reset_idle", {29'd0, o_busy, o_in_ready, o_done}, 32'd0);
    end
    drain();

    // len=1, passes=3
    dq = '{8'h77};
    push_job(dq, 3, 1'b1);
    i_out_ready = 1'b1;
    start_job(1, 3);
    send_word(8'h77);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spad_sequencer.md
SPAD_SEQUENCER -- requirements
Module: spad_sequencer

Interface
REQ-001 Parameter DATA_BITWIDTH, default 8, width of scratchpad data words.
REQ-002 Parameter ADDR_BITWIDTH, default 4, scratchpad address width; depth D = 2^ADDR_BITWIDTH.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rstN  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin a job; sampled only in IDLE.
REQ-006 clear  in  1  synchronous abort to IDLE; overrides all other inputs.
REQ-007 cfg_len  in  ADDR_BITWIDTH+1  entries per job, legal 1..D; captured at start.
REQ-008 cfg_passes  in  8  number of full read sweeps, legal 1..255; captured at start.
REQ-009 in_valid  in  1  fill data valid.
REQ-010 in_data  in  DATA_BITWIDTH  fill data word.
REQ-011 in_ready  out  1  sequencer accepts fill word this cycle.
REQ-012 rf_en  out  1  scratchpad read enable (read data valid when 1).
REQ-013 rf_we  out  1  scratchpad write enable (effective only while rf_en=0).
REQ-014 rf_wr_addr  out  ADDR_BITWIDTH  scratchpad write address.
REQ-015 rf_rd_addr  out  ADDR_BITWIDTH  scratchpad read address.
REQ-016 rf_din  out  DATA_BITWIDTH  scratchpad write data.
REQ-017 rf_dout  in  DATA_BITWIDTH  scratchpad read data, combinational from rf_rd_addr while rf_en=1.
REQ-018 out_valid  out  1  read stream beat valid.
REQ-019 out_data  out  DATA_BITWIDTH  read stream data.
REQ-020 out_last  out  1  marks final entry of the current sweep.
REQ-021 out_ready  in  1  downstream accepts beat.
REQ-022 busy  out  1  high in LOAD and COMPUTE.
REQ-023 done  out  1  single-cycle pulse at job completion.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, COMPUTE, DONE; registers: state, len, passes, wr_ptr, rd_ptr, pass_cnt.
REQ-025 IDLE: start=1 with legal cfg SHALL capture cfg_len/cfg_passes, zero wr_ptr/rd_ptr/pass_cnt, go to LOAD next cycle.
REQ-026 IDLE: start=1 with cfg_len=0, cfg_len>D or cfg_passes=0 SHALL pulse done next cycle (via DONE) with no scratchpad access.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 LOAD: in_ready=1, rf_en=0; rf_we = in_valid; rf_wr_addr=wr_ptr; rf_din=in_data (combinational pass-through).
REQ-029 LOAD: each in_valid&in_ready SHALL increment wr_ptr; handshake on wr_ptr=len-1 SHALL move to COMPUTE next cycle.
REQ-030 COMPUTE: rf_en=1, rf_we=0, in_ready=0, rf_rd_addr=rd_ptr, out_valid=1, out_data=rf_dout (zero added latency).
REQ-031 COMPUTE: out_last=1 iff rd_ptr=len-1.
REQ-032 COMPUTE: rd_ptr, rf_rd_addr, out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-033 COMPUTE: on out_ready with rd_ptr<len-1, rd_ptr increments; with rd_ptr=len-1, rd_ptr wraps to 0 and pass_cnt increments.
REQ-034 Accepted beat with out_last=1 and pass_cnt=passes-1 SHALL move to DONE.
REQ-035 DONE: done=1 for exactly one cycle, all other outputs at idle values, then IDLE.
REQ-036 rf_en and rf_we SHALL never both be 1 in any cycle.
REQ-037 IDLE and DONE: in_ready, rf_en, rf_we, out_valid, out_last, busy = 0.
REQ-038 clear=1 in any state SHALL return to IDLE next cycle without done; scratchpad contents untouched; rf_we forced 0 that cycle.
REQ-039 Full-depth job (len=D) SHALL address 0..D-1 with no pointer overflow; pointers are ADDR_BITWIDTH+1 wide internally.

Reset
REQ-040 rstN=0 SHALL immediately force state IDLE, all counters and captured config to 0, all outputs 0, independent of clk.
REQ-041 Reset mid-LOAD or mid-COMPUTE SHALL abort the job; no done pulse after release.

Verification
REQ-042 len=4, passes=2, fill 0x11,0x22,0x33,0x44 continuous -> 4 writes addr 0..3, then 8 beats 11,22,33,44,11,22,33,44, out_last on beats 4 and 8, done 1 cycle after beat 8.
REQ-043 len=16, passes=1, in_valid toggling 50% -> exactly 16 writes addr 0..15, 16 reads in order, rf_en&rf_we never 1.
REQ-044 COMPUTE with out_ready low 5 cycles at rd_ptr=2 -> rf_rd_addr=2 and out_data constant for all 5 cycles.
REQ-045 start with cfg_passes=0 -> no rf_we/rf_en, done pulse, busy stays 0.
REQ-046 clear asserted at third COMPUTE beat -> IDLE next cycle, no done; new start then runs a clean job.
REQ-047 rstN low mid-LOAD after 2 writes -> outputs 0 asynchronously; after release block idles until start.
